// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin share of one memory port between fetch and data requesters,
// one transaction in flight, with a response timeout that forces an error completion.
module riscv_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_err,
    output logic                  busy,
    output logic                  owner
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t            state;
    logic              prio;
    logic [15:0]       count;
    logic              done;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    // prio = 1 favours data; grants are masked while reset is held so every output reads 0
    assign d_gnt     = !reset && state == IDLE && d_req && (!if_req || prio);
    assign if_gnt    = !reset && state == IDLE && if_req && !d_gnt;
    assign mem_req   = state == ISSUE;
    assign busy      = state != IDLE;
    assign done      = state == WAIT_RESP && (mem_rvalid || count == TO_LAST);
    assign resp_data = (mem_rvalid && !mem_we) ? mem_rdata : '0;
    assign resp_err  = !mem_rvalid || mem_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prio      <= 1'b1;
            owner     <= 1'b0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: if (d_gnt || if_gnt) begin
                    state     <= ISSUE;
                    owner     <= d_gnt;
                    mem_we    <= d_gnt && d_we;
                    mem_be    <= d_gnt ? d_be : '1;
                    mem_addr  <= d_gnt ? d_addr : if_addr;
                    mem_wdata <= d_gnt ? d_wdata : '0;
                end
                ISSUE: if (mem_gnt) begin
                    state <= WAIT_RESP;
                    count <= '0;
                end
                WAIT_RESP: begin
                    count <= count + 16'd1;
                    if (done) begin
                        state <= IDLE;
                        prio  <= !owner;
                        if (owner) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= resp_data;
                            d_err    <= resp_err;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= resp_data;
                            if_err    <= resp_err;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed scenarios against riscv_mem_arbiter built with TIMEOUT = 4.
module tb_riscv_mem_arbiter;
    logic        clk = 0, reset = 0;
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  d_be = 0;
    logic        mem_gnt = 0, mem_rvalid = 0, mem_err = 0;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we, busy, owner;
    logic [3:0]  mem_be;
    int          n_vec = 0, n_err = 0;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired before summary");
        $fatal(1);
    end

    // inputs change 1 time unit after the rising edge; checks happen 1-2 units later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; if_req = 1; d_req = 1;
        #1;
        n_vec++;
        if ({if_gnt, d_gnt, mem_req, busy, owner, if_rvalid, d_rvalid, if_err, d_err} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 000000000",
                     {if_gnt, d_gnt, mem_req, busy, owner, if_rvalid, d_rvalid, if_err, d_err});
        end
        n_vec++;
        if ({if_rdata, d_rdata, mem_addr} !== 96'b0) begin
            n_err++;
            $display("FAIL reset_data: got %h %h %h required 0", if_rdata, d_rdata, mem_addr);
        end
        if_req = 0; d_req = 0;
        step(); step();
        reset = 0;
        step();
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 32'h100;
        #1;
        n_vec++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            n_err++; $display("FAIL fetch_gnt: got %b required 10", {if_gnt, d_gnt});
        end
        step();
        if_req = 0; if_addr = 32'hFFFF_FFFF;
        #1;
        n_vec++;
        if ({mem_req, mem_we, mem_be, busy, owner} !== 8'b1_0_1111_1_0 || mem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL fetch_issue: got req/we/be/busy/owner %b addr %h required 10111110 addr 00000100",
                     {mem_req, mem_we, mem_be, busy, owner}, mem_addr);
        end
        mem_gnt = 1;
        step();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00A00093;
        #1;
        n_vec++;
        if ({mem_req, busy, if_rvalid} !== 3'b010) begin
            n_err++; $display("FAIL fetch_wait: got req/busy/rvalid %b required 010", {mem_req, busy, if_rvalid});
        end
        step();
        mem_rvalid = 0; mem_rdata = 0;
        #1;
        n_vec++;
        if ({if_rvalid, if_err, busy} !== 3'b100 || if_rdata !== 32'h00A00093) begin
            n_err++;
            $display("FAIL fetch_resp: got rvalid/err/busy %b rdata %h required 100 00a00093",
                     {if_rvalid, if_err, busy}, if_rdata);
        end
        n_vec++;
        if ({d_rvalid, d_err, d_gnt} !== 3'b0 || d_rdata !== 32'h0) begin
            n_err++; $display("FAIL fetch_d_quiet: got %b rdata %h required 000 0", {d_rvalid, d_err, d_gnt}, d_rdata);
        end
        step();
        n_vec++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h00A00093) begin
            n_err++; $display("FAIL fetch_hold: got rvalid %b rdata %h required 0 00a00093", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_d;
        if_req = 1; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300; if_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            #1;
            n_vec++;
            if ({d_gnt, if_gnt} !== {exp_d, !exp_d}) begin
                n_err++; $display("FAIL rr_gnt%0d: got d/if %b required %b", k, {d_gnt, if_gnt}, {exp_d, !exp_d});
            end
            step();
            #1;
            n_vec++;
            if (owner !== exp_d || mem_addr !== (exp_d ? 32'h300 : 32'h200)) begin
                n_err++; $display("FAIL rr_owner%0d: got owner %b addr %h required %b", k, owner, mem_addr, exp_d);
            end
            mem_gnt = 1;
            step();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1000 + k;
            step();
            mem_rvalid = 0;
            if (k == 3) begin if_req = 0; d_req = 0; end
            #1;
            n_vec++;
            if ({d_rvalid, if_rvalid} !== {exp_d, !exp_d} || (exp_d ? d_rdata : if_rdata) !== 32'h1000 + k) begin
                n_err++;
                $display("FAIL rr_resp%0d: got d/if rvalid %b data d %h if %h required %b %h",
                         k, {d_rvalid, if_rvalid}, d_rdata, if_rdata, {exp_d, !exp_d}, 32'h1000 + k);
            end
        end
        step();
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        #1;
        n_vec++;
        if (d_gnt !== 1'b1) begin n_err++; $display("FAIL st_gnt: got %b required 1", d_gnt); end
        step();
        d_req = 0; d_we = 0; d_be = 4'hF; d_addr = 32'hFFFF; d_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if ({mem_req, mem_we, mem_be, d_rvalid} !== 7'b1_1_0011_0 || mem_addr !== 32'h2000 ||
                mem_wdata !== 32'hDEADBEEF) begin
                n_err++;
                $display("FAIL st_issue%0d: got req/we/be/rvalid %b addr %h wdata %h required 1100110 2000 deadbeef",
                         i, {mem_req, mem_we, mem_be, d_rvalid}, mem_addr, mem_wdata);
            end
            if (i == 1) begin mem_rvalid = 1; mem_rdata = 32'h55; end
            if (i == 3) mem_gnt = 1;
            step();
            mem_rvalid = 0; mem_gnt = 0;
        end
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        step();
        mem_rvalid = 0;
        #1;
        n_vec++;
        if ({d_rvalid, d_err, if_rvalid} !== 3'b100 || d_rdata !== 32'h0) begin
            n_err++; $display("FAIL st_resp: got %b rdata %h required 100 0", {d_rvalid, d_err, if_rvalid}, d_rdata);
        end
        step();
    endtask

    task automatic test_timeout();
        d_req = 1; d_we = 0; d_addr = 32'h40;
        #1;
        n_vec++;
        if (d_gnt !== 1'b1) begin n_err++; $display("FAIL to_gnt: got %b required 1", d_gnt); end
        step();
        d_req = 0; mem_gnt = 1;
        step();
        mem_gnt = 0;
        for (int j = 1; j <= 4; j++) begin
            #1;
            n_vec++;
            if ({d_rvalid, busy} !== 2'b01) begin
                n_err++; $display("FAIL to_wait%0d: got rvalid/busy %b required 01", j, {d_rvalid, busy});
            end
            step();
        end
        #1;
        n_vec++;
        if ({d_rvalid, d_err, busy} !== 3'b110 || d_rdata !== 32'h0) begin
            n_err++; $display("FAIL to_resp: got rvalid/err/busy %b rdata %h required 110 0", {d_rvalid, d_err, busy}, d_rdata);
        end
        mem_rvalid = 1; mem_rdata = 32'hAA;
        step();
        mem_rvalid = 0;
        #1;
        n_vec++;
        if ({d_rvalid, if_rvalid, d_err} !== 3'b001 || d_rdata !== 32'h0) begin
            n_err++; $display("FAIL to_stale: got %b rdata %h required 001 0", {d_rvalid, if_rvalid, d_err}, d_rdata);
        end
        step();
    endtask

    task automatic test_fetch_error();
        for (int e = 1; e >= 0; e--) begin
            if_req = 1; if_addr = 32'h400;
            #1;
            n_vec++;
            if (if_gnt !== 1'b1) begin n_err++; $display("FAIL ferr_gnt%0d: got %b required 1", e, if_gnt); end
            step();
            if_req = 0; mem_gnt = 1;
            step();
            mem_gnt = 0; mem_rvalid = 1; mem_err = e[0]; mem_rdata = e ? 32'hBAD : 32'h13;
            step();
            mem_rvalid = 0; mem_err = 0;
            #1;
            n_vec++;
            if ({if_rvalid, if_err, d_rvalid} !== {1'b1, e[0], 1'b0} || if_rdata !== (e ? 32'hBAD : 32'h13)) begin
                n_err++;
                $display("FAIL ferr_resp%0d: got rvalid/err/d_rvalid %b rdata %h required %b", e,
                         {if_rvalid, if_err, d_rvalid}, if_rdata, {1'b1, e[0], 1'b0});
            end
            step();
        end
    endtask

    task automatic test_reset_in_wait();
        if_req = 1; if_addr = 32'h500;
        step();
        if_req = 0; mem_gnt = 1;
        step();
        mem_gnt = 0;
        #1;
        n_vec++;
        if ({busy, mem_req} !== 2'b10) begin
            n_err++; $display("FAIL rw_pre: got busy/req %b required 10", {busy, mem_req});
        end
        reset = 1; mem_rvalid = 1; mem_rdata = 32'h77;
        #1;
        n_vec++;
        if ({mem_req, busy, if_rvalid, d_rvalid, owner} !== 5'b0) begin
            n_err++; $display("FAIL rw_reset: got %b required 00000", {mem_req, busy, if_rvalid, d_rvalid, owner});
        end
        step();
        n_vec++;
        if ({if_rvalid, d_rvalid, if_rdata} !== 34'b0) begin
            n_err++; $display("FAIL rw_no_resp: got %b %b %h required 0 0 0", if_rvalid, d_rvalid, if_rdata);
        end
        reset = 0; mem_rvalid = 0;
        step();
        if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h600;
        #1;
        n_vec++;
        if ({d_gnt, if_gnt} !== 2'b10) begin
            n_err++; $display("FAIL rw_gnt: got d/if %b required 10", {d_gnt, if_gnt});
        end
        step();
        if_req = 0; d_req = 0;
        #1;
        n_vec++;
        if ({mem_req, owner} !== 2'b11 || mem_addr !== 32'h600) begin
            n_err++; $display("FAIL rw_issue: got req/owner %b addr %h required 11 600", {mem_req, owner}, mem_addr);
        end
        mem_gnt = 1;
        step();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h99;
        step();
        mem_rvalid = 0;
        #1;
        n_vec++;
        if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 32'h99) begin
            n_err++; $display("FAIL rw_resp: got rvalid/err %b rdata %h required 10 99", {d_rvalid, d_err}, d_rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_store();
        test_timeout();
        test_fetch_error();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
